// File: rtl/axi_rd_arbiter.sv
// Two-client AXI read-port arbiter: round-robin AR grant into a registered stage,
// source-tagged IDs, tag-based R routing and a per-client outstanding-burst cap.
module axi_rd_arbiter #(
  parameter int ID_W    = 16,
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 512,
  parameter int MAX_OUT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ID_W-2:0]   rq0_arid,
  input  logic [ADDR_W-1:0] rq0_araddr,
  input  logic [7:0]        rq0_arlen,
  input  logic [2:0]        rq0_arsize,
  input  logic              rq0_arvalid,
  output logic              rq0_arready,
  input  logic [ID_W-2:0]   rq1_arid,
  input  logic [ADDR_W-1:0] rq1_araddr,
  input  logic [7:0]        rq1_arlen,
  input  logic [2:0]        rq1_arsize,
  input  logic              rq1_arvalid,
  output logic              rq1_arready,
  output logic [ID_W-2:0]   rq0_rid,
  output logic [DATA_W-1:0] rq0_rdata,
  output logic [1:0]        rq0_rresp,
  output logic              rq0_rlast,
  output logic              rq0_rvalid,
  input  logic              rq0_rready,
  output logic [ID_W-2:0]   rq1_rid,
  output logic [DATA_W-1:0] rq1_rdata,
  output logic [1:0]        rq1_rresp,
  output logic              rq1_rlast,
  output logic              rq1_rvalid,
  input  logic              rq1_rready,
  output logic [ID_W-1:0]   arid_m,
  output logic [ADDR_W-1:0] araddr_m,
  output logic [7:0]        arlen_m,
  output logic [2:0]        arsize_m,
  output logic              arvalid_m,
  input  logic              arready_m,
  input  logic [ID_W-1:0]   rid_m,
  input  logic [DATA_W-1:0] rdata_m,
  input  logic [1:0]        rresp_m,
  input  logic              rlast_m,
  input  logic              rvalid_m,
  output logic              rready_m,
  output logic              busy
);

  localparam logic [7:0] MAX_CNT = 8'(MAX_OUT);

  logic [ID_W-1:0]   r_arid;
  logic [ADDR_W-1:0] r_araddr;
  logic [7:0]        r_arlen;
  logic [2:0]        r_arsize;
  logic              r_arvalid;
  logic              r_last_grant;
  logic [7:0]        r_cnt0;
  logic [7:0]        r_cnt1;

  logic w_load;
  logic w_elig0;
  logic w_elig1;
  logic w_grant0;
  logic w_grant1;
  logic w_src;
  logic w_rdone0;
  logic w_rdone1;

  assign w_load   = !r_arvalid || arready_m;
  assign w_elig0  = rq0_arvalid && (r_cnt0 < MAX_CNT);
  assign w_elig1  = rq1_arvalid && (r_cnt1 < MAX_CNT);
  // On a tie the requester that did not win last time takes the grant.
  assign w_grant0 = w_load && w_elig0 && (!w_elig1 || r_last_grant);
  assign w_grant1 = w_load && w_elig1 && (!w_elig0 || !r_last_grant);

  assign rq0_arready = w_grant0;
  assign rq1_arready = w_grant1;

  assign arid_m    = r_arid;
  assign araddr_m  = r_araddr;
  assign arlen_m   = r_arlen;
  assign arsize_m  = r_arsize;
  assign arvalid_m = r_arvalid;

  assign w_src      = rid_m[ID_W-1];
  assign rq0_rvalid = rvalid_m && !w_src;
  assign rq1_rvalid = rvalid_m && w_src;
  assign rready_m   = w_src ? rq1_rready : rq0_rready;
  assign rq0_rid    = rid_m[ID_W-2:0];
  assign rq1_rid    = rid_m[ID_W-2:0];
  assign rq0_rdata  = rdata_m;
  assign rq1_rdata  = rdata_m;
  assign rq0_rresp  = rresp_m;
  assign rq1_rresp  = rresp_m;
  assign rq0_rlast  = rlast_m;
  assign rq1_rlast  = rlast_m;

  assign w_rdone0 = rvalid_m && rready_m && rlast_m && !w_src;
  assign w_rdone1 = rvalid_m && rready_m && rlast_m && w_src;

  assign busy = r_arvalid || (r_cnt0 != 8'd0) || (r_cnt1 != 8'd0);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_arvalid    <= 1'b0;
      r_arid       <= '0;
      r_araddr     <= '0;
      r_arlen      <= '0;
      r_arsize     <= '0;
      r_last_grant <= 1'b1;
    end else if (w_load) begin
      if (w_grant0) begin
        r_arvalid    <= 1'b1;
        r_arid       <= {1'b0, rq0_arid};
        r_araddr     <= rq0_araddr;
        r_arlen      <= rq0_arlen;
        r_arsize     <= rq0_arsize;
        r_last_grant <= 1'b0;
      end else if (w_grant1) begin
        r_arvalid    <= 1'b1;
        r_arid       <= {1'b1, rq1_arid};
        r_araddr     <= rq1_araddr;
        r_arlen      <= rq1_arlen;
        r_arsize     <= rq1_arsize;
        r_last_grant <= 1'b1;
      end else begin
        r_arvalid <= 1'b0;
      end
    end
  end

  // Simultaneous accept and completion cancel out; completion at zero is ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt0 <= 8'd0;
      r_cnt1 <= 8'd0;
    end else begin
      if (w_grant0 && !w_rdone0)                        r_cnt0 <= r_cnt0 + 8'd1;
      else if (w_rdone0 && !w_grant0 && r_cnt0 != 8'd0) r_cnt0 <= r_cnt0 - 8'd1;
      if (w_grant1 && !w_rdone1)                        r_cnt1 <= r_cnt1 + 8'd1;
      else if (w_rdone1 && !w_grant1 && r_cnt1 != 8'd0) r_cnt1 <= r_cnt1 - 8'd1;
    end
  end

endmodule
